// File: rtl/mchan_arb_out_buf_ipa.sv
// rtl/mchan_arb_out_buf_ipa.sv - Two-entry elastic output buffer and round-robin flag owner for the MCHAN arbitration tree
//
// Purpose:
//   Sits directly below the root of the MCHAN request arbitration tree. It
//   accepts the winning request into a 2-entry FIFO and forwards it toward the
//   TCDM/ext port. The grant back to the tree comes only from registered
//   occupancy, so there is no combinational path from gnt_i to gnt_o. The block
//   also keeps the round-robin counter whose bits drive RR_FLAG of each tree
//   level. That counter advances once per accepted request.
//
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset
//   req_i      - request from arbitration tree root
//   gnt_o      - grant to tree root (buffer not full)
//   data_i     - request payload from tree
//   id_i       - request core/channel id from tree
//   rr_flag_o  - round-robin flags, bit k drives tree level k
//   req_o      - request toward port (buffer not empty)
//   gnt_i      - grant from port
//   data_o     - head-entry payload
//   id_o       - head-entry id
//   count_o    - occupancy 0..2

module mchan_arb_out_buf_ipa #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int RR_WIDTH   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    output logic [RR_WIDTH-1:0]   rr_flag_o,
    output logic                  req_o,
    input  logic                  gnt_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ID_WIDTH-1:0]   id_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] data_q [2];
    logic [ID_WIDTH-1:0]   id_q   [2];
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic [1:0]            count_q, count_d;
    logic [RR_WIDTH-1:0]   rr_q, rr_d;

    logic push;
    logic pop;

    // Both handshakes are derived from registered occupancy. This keeps the
    // port grant from reaching back into the arbiter primitives.
    assign gnt_o = (count_q != 2'd2);
    assign req_o = (count_q != 2'd0);

    assign push = req_i & gnt_o;
    assign pop  = req_o & gnt_i;

    // The head entry is read straight from storage. An empty buffer never
    // bypasses data_i to the output.
    assign data_o    = data_q[rptr_q];
    assign id_o      = id_q[rptr_q];
    assign count_o   = count_q;
    assign rr_flag_o = rr_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rr_d    = rr_q;

        if (push) begin
            wptr_d = ~wptr_q;
            // Advance priority so the tree sees it on its next arbitration.
            rr_d   = rr_q + RR_WIDTH'(1);
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end

        // Push and pop together leave occupancy unchanged.
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
            rr_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                id_q[i]   <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            if (push) begin
                data_q[wptr_q] <= data_i;
                id_q[wptr_q]   <= id_i;
            end
        end
    end

endmodule

// File: tb/tb_mchan_arb_out_buf_ipa.sv
// tb/tb_mchan_arb_out_buf_ipa.sv - Self-checking bench for mchan_arb_out_buf_ipa against a queue-based reference
module tb_mchan_arb_out_buf_ipa;

    logic        clk;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] data_i;
    logic [3:0]  id_i;
    logic [1:0]  rr_flag_o;
    logic        req_o;
    logic        gnt_i;
    logic [31:0] data_o;
    logic [3:0]  id_o;
    logic [1:0]  count_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of {data,id} with capacity 2, and a modulo-4 push counter.
    logic [35:0] mq[$];
    int          rr_m = 0;

    mchan_arb_out_buf_ipa #(
        .DATA_WIDTH(32),
        .ID_WIDTH  (4),
        .RR_WIDTH  (2)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .data_i   (data_i),
        .id_i     (id_i),
        .rr_flag_o(rr_flag_o),
        .req_o    (req_o),
        .gnt_i    (gnt_i),
        .data_o   (data_o),
        .id_o     (id_o),
        .count_o  (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        check("req_o",   {35'd0, req_o},   {35'd0, n != 0});
        check("gnt_o",   {35'd0, gnt_o},   {35'd0, n != 2});
        check("count_o", {34'd0, count_o}, 36'(n));
        check("rr_flag", {34'd0, rr_flag_o}, 36'(rr_m % 4));
        if (n != 0) begin
            check("data_o", {4'd0, data_o}, {4'd0, mq[0][35:4]});
            check("id_o",   {32'd0, id_o},  {32'd0, mq[0][3:0]});
        end
    endtask

    // The caller is at a negedge. The task checks the outputs, drives the
    // inputs, steps the model at the posedge and returns at the next negedge.
    task automatic cycle(input logic r, input logic [31:0] d, input logic [3:0] id, input logic g);
        logic push, pop;
        check_model();
        req_i  = r;
        data_i = d;
        id_i   = id;
        gnt_i  = g;
        push = r && (mq.size() < 2);
        pop  = (mq.size() > 0) && g;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back({d, id});
            rr_m = (rr_m + 1) % 4;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {35'd0, req_o},     36'd0);
        check({tag, "_gnt"},   {35'd0, gnt_o},     36'd1);
        check({tag, "_count"}, {34'd0, count_o},   36'd0);
        check({tag, "_rr"},    {34'd0, rr_flag_o}, 36'd0);
        check({tag, "_data"},  {4'd0, data_o},     36'd0);
        check({tag, "_id"},    {32'd0, id_o},      36'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        req_i  = 1'b0;
        data_i = '0;
        id_i   = '0;
        gnt_i  = 1'b0;

        // Reset with random inputs: the outputs must hold their reset values.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_i  = 1'($urandom);
            data_i = $urandom;
            id_i   = 4'($urandom);
            gnt_i  = 1'($urandom);
            #1;
            check_reset_outputs("rst");
        end
        req_i  = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk);
        // After release, no push has happened, so nothing may change.
        cycle(1'b0, $urandom, 4'($urandom), 1'($urandom));
        cycle(1'b0, $urandom, 4'($urandom), 1'($urandom));
        check_reset_outputs("post_rst");

        // Single transfer.
        cycle(1'b1, 32'hA5A5_0001, 4'd3, 1'b1);
        check("single_req",  {35'd0, req_o},     36'd1);
        check("single_data", {4'd0, data_o},     {4'd0, 32'hA5A5_0001});
        check("single_id",   {32'd0, id_o},      36'd3);
        check("single_rr",   {34'd0, rr_flag_o}, 36'd1);
        cycle(1'b0, 32'h0, 4'd0, 1'b1);
        check("single_empty", {35'd0, req_o}, 36'd0);

        // Fill under back-pressure, then drain in order.
        cycle(1'b1, 32'h11, 4'd1, 1'b0);
        cycle(1'b1, 32'h22, 4'd2, 1'b0);
        check("full_count", {34'd0, count_o}, 36'd2);
        check("full_gnt",   {35'd0, gnt_o},   36'd0);
        cycle(1'b1, 32'h33, 4'd3, 1'b0);   // held request is not accepted
        check("stall_rr",   {34'd0, rr_flag_o}, 36'd3);
        check("full_head",  {4'd0, data_o},     {4'd0, 32'h11});
        cycle(1'b0, 32'h0, 4'd0, 1'b1);
        check("pop1_gnt",   {35'd0, gnt_o},     36'd1);
        check("pop1_head",  {4'd0, data_o},     {4'd0, 32'h22});
        cycle(1'b0, 32'h0, 4'd0, 1'b1);
        check("drained",    {34'd0, count_o},   36'd0);

        // Streaming at full rate: occupancy stays at 1 with no gaps.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'(i), 4'(i), 1'b1);
            check("stream_count", {34'd0, count_o}, 36'd1);
            check("stream_data",  {4'd0, data_o},   36'(i));
        end
        cycle(1'b0, 32'h0, 4'd0, 1'b1);

        // RR wrap: 5 pushes step the flags through the model's modulo-4 count.
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 4'($urandom), 1'b1);
        cycle(1'b0, 32'h0, 4'd0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, $urandom, 4'($urandom), ($urandom % 3) != 0);
        end

        // Reset mid-operation with a full buffer.
        cycle(1'b0, 32'h0, 4'd0, 1'b1);
        cycle(1'b0, 32'h0, 4'd0, 1'b1);
        cycle(1'b1, 32'hDEAD_0001, 4'd5, 1'b0);
        cycle(1'b1, 32'hDEAD_0002, 4'd6, 1'b0);
        check("pre_rst_count", {34'd0, count_o}, 36'd2);
        req_i  = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        mq.delete();
        rr_m = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        cycle(1'b1, 32'hBEEF_0003, 4'd7, 1'b0);
        check("new_data",  {4'd0, data_o},   {4'd0, 32'hBEEF_0003});
        check("new_count", {34'd0, count_o}, 36'd1);
        cycle(1'b0, 32'h0, 4'd0, 1'b1);
        check("new_empty", {35'd0, req_o},   36'd0);
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
